// File: rtl/keypad_emulator.sv
// Switch-matrix end of a 4x4 keypad: plays back "press key k for N units" commands
// on the column lines in response to row strobes, with LFSR contact bounce.
module keypad_emulator #(
   parameter int unsigned BOUNCE_CYCLES  = 250000,
   parameter int unsigned CHATTER_CYCLES = 2500,
   parameter int unsigned HOLD_UNIT      = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_key,
   input  logic [15:0] cmd_hold,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   output logic        contact,
   output logic        busy,
   output logic        done,
   output logic [1:0]  dbg_state
);

   // Handshake: a command is taken on any cycle where cmd_valid && cmd_ready;
   // cmd_ready is high only in IDLE and there is no queueing while busy.

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BNC_DN = 2'd1,
      HOLD   = 2'd2,
      BNC_UP = 2'd3
   } state_t;

   localparam bit          BNC_EN    = (BOUNCE_CYCLES != 0);
   localparam logic [31:0] B_LAST    = 32'(BOUNCE_CYCLES - 1);
   localparam logic [31:0] CHAT_LAST = 32'(CHATTER_CYCLES - 1);
   localparam logic [31:0] HU        = 32'(HOLD_UNIT);

   state_t      state, state_n;
   logic [31:0] cnt, cnt_n;
   logic [31:0] chat_cnt;
   logic [15:0] lfsr;
   logic [3:0]  key_r;
   logic [15:0] hold_r;
   logic [31:0] cmd_hold_cycles;
   logic [31:0] hold_cycles;
   logic        accept;
   logic        lfsr_fb;

   // 65535 * HOLD_UNIT must fit; both operands are widened before multiplying.
   assign cmd_hold_cycles = 32'(cmd_hold) * HU;
   assign hold_cycles     = 32'(hold_r) * HU;
   assign accept          = cmd_valid && (state == IDLE);
   assign lfsr_fb         = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         chat_cnt <= '0;
         lfsr     <= 16'hACE1;
         key_r    <= '0;
         hold_r   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (accept) begin
            key_r  <= cmd_key;
            hold_r <= cmd_hold;
         end
         // Chatter only advances inside a bounce window; the LFSR freezes elsewhere.
         if (state == BNC_DN || state == BNC_UP) begin
            if (chat_cnt == CHAT_LAST) begin
               chat_cnt <= '0;
               lfsr     <= {lfsr_fb, lfsr[15:1]};
            end else begin
               chat_cnt <= chat_cnt + 32'd1;
            end
         end else begin
            chat_cnt <= '0;
         end
      end
   end

   // cnt holds the remaining cycles of the current state minus one.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      contact   = 1'b0;
      cmd_ready = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               if (BNC_EN) begin
                  state_n = BNC_DN;
                  cnt_n   = B_LAST;
               end else if (cmd_hold_cycles != 32'd0) begin
                  state_n = HOLD;
                  cnt_n   = cmd_hold_cycles - 32'd1;
               end else begin
                  // Single release cycle: contact stays 0, done follows at once.
                  state_n = BNC_UP;
                  cnt_n   = '0;
               end
            end
         end
         BNC_DN: begin
            contact = (cnt == 32'd0) ? 1'b1 : lfsr[0];
            if (cnt == 32'd0) begin
               if (hold_cycles != 32'd0) begin
                  state_n = HOLD;
                  cnt_n   = hold_cycles - 32'd1;
               end else begin
                  state_n = BNC_UP;
                  cnt_n   = B_LAST;
               end
            end else begin
               cnt_n = cnt - 32'd1;
            end
         end
         HOLD: begin
            contact = 1'b1;
            if (cnt == 32'd0) begin
               if (BNC_EN) begin
                  state_n = BNC_UP;
                  cnt_n   = B_LAST;
               end else begin
                  state_n = IDLE;
                  done    = 1'b1;
               end
            end else begin
               cnt_n = cnt - 32'd1;
            end
         end
         BNC_UP: begin
            contact = (cnt == 32'd0) ? 1'b0 : lfsr[0];
            if (cnt == 32'd0) begin
               state_n = IDLE;
               done    = 1'b1;
            end else begin
               cnt_n = cnt - 32'd1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // Passive switch: only the selected key's row and column matter.
   always_comb begin
      col = 4'b1111;
      if (contact && !row[key_r[3:2]])
         col[key_r[1:0]] = 1'b0;
   end

   assign busy      = (state != IDLE);
   assign dbg_state = state;

endmodule
